// File: rtl/pic_fetch_unit.sv
// Instruction-fetch stage: owns the PC, latches ROM words into IR, resolves
// GOTO/CALL/RETURN/RETLW/RETFIE and keeps the hardware return stack.
module pic_fetch_unit #(
  parameter int ADDR_W = 11,
  parameter int INSTR_W = 14,
  parameter int STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  input  logic               stall,
  input  logic               skip,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_valid,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic [3:0]         stack_depth,
  output logic               stack_ovf,
  output logic               stack_unf
);

  localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [3:0] DEPTH_FULL = 4'(STACK_DEPTH);

  typedef enum logic {FETCH0, RUN} state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   pc, pc_next, pc_inc, stack_top;
  logic [ADDR_W-1:0]   stk [STACK_DEPTH];
  logic [PTR_W-1:0]    ptr;
  logic                push, pop, load, valid_next;
  logic                is_goto, is_call, is_ret;

  function automatic logic dec_goto(input logic [INSTR_W-1:0] w);
    return w[INSTR_W-1 -: 3] == 3'b101;
  endfunction

  function automatic logic dec_call(input logic [INSTR_W-1:0] w);
    return w[INSTR_W-1 -: 3] == 3'b100;
  endfunction

  function automatic logic dec_ret(input logic [INSTR_W-1:0] w);
    return (w == INSTR_W'(14'h0008)) || (w == INSTR_W'(14'h0009)) ||
           (w[INSTR_W-1 -: 4] == 4'b1101);
  endfunction

  assign rom_addr  = pc;
  assign pc_inc    = pc + ADDR_W'(1);
  assign stack_top = stk[ptr - PTR_W'(1)];
  assign is_goto   = dec_goto(ir);
  assign is_call   = dec_call(ir);
  assign is_ret    = dec_ret(ir);

  // Every unstalled edge loads IR; a transfer or skip only marks it a bubble.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    load       = 1'b0;
    valid_next = ir_valid;
    push       = 1'b0;
    pop        = 1'b0;
    if (!stall) begin
      load       = 1'b1;
      valid_next = 1'b1;
      pc_next    = pc_inc;
      case (state)
        FETCH0: state_next = RUN;
        RUN: begin
          if (ir_valid) begin
            if (is_goto) begin
              pc_next    = ir[ADDR_W-1:0];
              valid_next = 1'b0;
            end else if (is_call) begin
              push       = 1'b1;
              pc_next    = ir[ADDR_W-1:0];
              valid_next = 1'b0;
            end else if (is_ret) begin
              pop        = 1'b1;
              pc_next    = (stack_depth == 4'd0) ? RESET_VECTOR : stack_top;
              valid_next = 1'b0;
            end else if (skip) begin
              valid_next = 1'b0;
            end
          end
        end
        default: state_next = FETCH0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH0;
      pc          <= RESET_VECTOR;
      ir          <= '0;
      ir_valid    <= 1'b0;
      ir_pc       <= '0;
      ptr         <= '0;
      stack_depth <= '0;
      stack_ovf   <= 1'b0;
      stack_unf   <= 1'b0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      ir_valid <= valid_next;
      if (load) begin
        ir    <= rom_data;
        ir_pc <= pc;
      end
      if (push) begin
        ptr <= ptr + PTR_W'(1);
        if (stack_depth == DEPTH_FULL) stack_ovf <= 1'b1;
        else stack_depth <= stack_depth + 4'd1;
      end
      if (pop) begin
        // Underflow leaves the pointer alone so the stack stays consistent.
        if (stack_depth == 4'd0) begin
          stack_unf <= 1'b1;
        end else begin
          ptr         <= ptr - PTR_W'(1);
          stack_depth <= stack_depth - 4'd1;
        end
      end
    end
  end

  // Stack contents carry no reset; a push that races reset is dropped.
  always_ff @(posedge clk) begin
    if (push && !reset) stk[ptr] <= pc;
  end

endmodule

// File: doc/pic_fetch_unit.md
Name: pic_fetch_unit

Overview:
- Instruction-fetch stage that sits directly downstream of Program_Rom in the 14-bit-instruction PIC-style core.
- Owns the 11-bit program counter, drives the ROM address, and latches the returned word into the instruction register (IR) for the execute stage.
- Resolves GOTO/CALL/RETURN/RETLW/RETFIE itself and maintains the hardware return stack.
- Inserts flush bubbles for taken branches and for skips signalled by execute.

Parameters:
ADDR_W, 11, program-counter / ROM address width
INSTR_W, 14, instruction width
STACK_DEPTH, 8, return-stack entries; must be a power of 2
RESET_VECTOR, 11'h000, PC value after reset

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
rom_addr  output  ADDR_W  address to Program_Rom; equals PC register (no combinational path from inputs)
rom_data  input  INSTR_W  combinational ROM word for rom_addr
stall  input  1  execute-stage hold; freezes PC, IR, ir_valid, stack
skip  input  1  execute says the current IR's skip condition is true; discard the word being fetched
ir  output  INSTR_W  instruction register to execute
ir_valid  output  1  1 = ir holds a real instruction; 0 = bubble (treat as NOP)
ir_pc  output  ADDR_W  address the current ir was fetched from
stack_depth  output  4  entries currently on stack, 0..STACK_DEPTH, saturating
stack_ovf  output  1  sticky: push while full
stack_unf  output  1  sticky: pop while empty

Behaviour:
- Reset values: PC=RESET_VECTOR, ir=0, ir_valid=0, ir_pc=0, stack_depth=0, stack_ovf=0, stack_unf=0, stack pointer=0. Stack contents are not reset.
- Reset asserted mid-operation aborts everything at once; the first fetch after release is RESET_VECTOR.
- Pipeline:
  - In the cycle IR holds the word from address A, PC=A+1 is being fetched.
  - Normal edge: ir<=rom_data, ir_pc<=PC, ir_valid<=1, PC<=PC+1.
  - ROM-to-IR latency is 1 clock.
  - Taken branches and skips cost exactly 1 bubble.
- Decode of ir, only when ir_valid=1:
  - GOTO (ir[13:11]=3'b101): PC<=ir[10:0], ir_valid<=0.
  - CALL (ir[13:11]=3'b100): push PC (the return address A+1), PC<=ir[10:0], ir_valid<=0.
  - RETURN (14'h0008), RETFIE (14'h0009), RETLW (ir[13:10]=4'b1101): pop into PC, ir_valid<=0.
  - On every transfer, the word fetched that cycle is discarded; ir is still loaded with it, but ir_valid=0.
- Priority per edge: reset > stall > control transfer (ir_valid=1) > skip (ir_valid=1) > sequential.
  - skip with ir_valid=0 is ignored.
  - skip coincident with a control transfer is ignored.
- skip: PC<=PC+1, ir loaded, ir_valid<=0, so exactly one word is skipped.
- stall=1: no register changes at all; rom_addr stays constant.
- PC increment wraps 11'h7FF -> 11'h000. Branch targets use all 11 bits; no PCLATH in this block.
- Stack:
  - Circular buffer of STACK_DEPTH x ADDR_W with a log2(STACK_DEPTH)-bit pointer.
  - Push writes at ptr, ptr+1 (wraps). Pop reads at ptr-1, ptr-1.
  - stack_depth increments on push, saturating at STACK_DEPTH; decrements on pop, floor 0.
  - Push at depth=STACK_DEPTH: entry written, oldest overwritten, stack_ovf<=1.
  - Pop at depth=0: PC<=RESET_VECTOR instead of stack data, ptr unchanged, stack_unf<=1.
  - Flags are cleared only by reset.
- One FSM, {FETCH0, RUN}:
  - FETCH0 is entered from reset; its first edge loads ir from RESET_VECTOR and moves to RUN.
  - No decode or skip is honoured in FETCH0.
  - stall holds FETCH0.

Test Plan:
1. Demo ROM image (addr 0..F alternating 3000,008D,3000,008D,3009,008D,...,3006,008D; addr 10=2800) -> after reset, ir sequence 3000,008D,... at ir_pc 0..F. ir=2800 at ir_pc 10 is followed by one ir_valid=0 cycle, then ir=3000 at ir_pc 0; loop repeats every 18 cycles.
2. ROM[2]=2005 (CALL 5), ROM[5]=3442 (RETLW 42) -> depth becomes 1 with entry 003. Bubble after CALL, ir_pc=5. Bubble after RETLW. Next valid ir_pc=3, depth=0, no flags.
3. skip asserted while ir_pc=4, ir_valid=1 -> next cycle ir_valid=0. Following valid ir_pc=6.
4. stall held 3 cycles mid-stream -> rom_addr, ir, ir_pc, ir_valid unchanged for 3 cycles, then sequence resumes without loss or duplication.
5. Nine nested CALLs without return -> stack_depth=8 and stack_ovf=1 after the 9th. Eight RETURNs then return to the 9th, 8th, ..., 2nd return addresses.
6. RETURN (0008) with empty stack -> PC=000 after the bubble, stack_unf=1. Asserting reset mid-stream then clears flags, rom_addr=000 immediately (asynchronously), and ir_valid=0.
